// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU definitions used by the writeback arbiter: default widths,
// grant encoding and the saturating counter helper.
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT   = 5;
    localparam int unsigned CNT_W        = 16;

    // Encoding of last_grant: which requester won most recently
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two writeback requesters, the register-file write port and
// the arbiter status outputs.
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN = regfile_wb_arbiter_pkg::XLEN_DEFAULT,
    parameter int unsigned AW   = regfile_wb_arbiter_pkg::AW_DEFAULT
);
    logic                                     a_valid;
    logic [AW-1:0]                            a_rd;
    logic [XLEN-1:0]                          a_data;
    logic                                     a_ready;
    logic                                     b_valid;
    logic [AW-1:0]                            b_rd;
    logic [XLEN-1:0]                          b_data;
    logic                                     b_ready;
    logic                                     wb_wen;
    logic [AW-1:0]                            wb_rd;
    logic [XLEN-1:0]                          wb_data;
    logic                                     last_grant;
    logic [regfile_wb_arbiter_pkg::CNT_W-1:0] conflict_cnt;

    // Requester / register-file side
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, wb_wen, wb_rd, wb_data, last_grant, conflict_cnt
    );

    // Arbiter side
    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, wb_wen, wb_rd, wb_data, last_grant, conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant cell. Readies are combinational from the valids
// and the stored last grant; the stored grant follows every actual grant.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_ready,
    output logic b_ready,
    output logic last_grant
);

    grant_e last_q;

    // Grant selection: contention goes to whoever did not win last time
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                a_ready = (last_q == GRANT_B);
                b_ready = (last_q == GRANT_A);
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    // Remember the winner; reset to B so A wins the first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GRANT_B;
        end else if (a_ready) begin
            last_q <= GRANT_A;
        end else if (b_ready) begin
            last_q <= GRANT_B;
        end
    end

    assign last_grant = last_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: picks one of ALU / load-unit writes per
// cycle and registers it onto the register-file write port one cycle later.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned AW   = AW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_arbiter_if.slave bus
);

    logic             grant;
    logic [AW-1:0]    sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic             wen_q;
    logic [AW-1:0]    rd_q;
    logic [XLEN-1:0]  data_q;
    logic [CNT_W-1:0] cnt_q;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (bus.a_valid),
        .b_valid    (bus.b_valid),
        .a_ready    (bus.a_ready),
        .b_ready    (bus.b_ready),
        .last_grant (bus.last_grant)
    );

    // Mux the granted requester's destination and data
    always_comb begin
        grant    = bus.a_ready | bus.b_ready;
        sel_rd   = bus.a_ready ? bus.a_rd : bus.b_rd;
        sel_data = bus.a_ready ? bus.a_data : bus.b_data;
    end

    // Output register: x0 writes are consumed but never enabled; address and
    // data hold when nothing was granted
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            wen_q <= grant && (sel_rd != '0);
            if (grant) begin
                rd_q   <= sel_rd;
                data_q <= sel_data;
            end
        end
    end

    // Saturating count of cycles with both requesters valid
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.a_valid && bus.b_valid) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign bus.wb_wen       = wen_q;
    assign bus.wb_rd        = rd_q;
    assign bus.wb_data      = data_q;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a writeback scoreboard.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_item_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    wb_item_t    q[$];
    logic [31:0] rf[32];

    // Reference model state
    logic        m_last;
    logic [15:0] m_cnt;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    // Readies seen in the most recent cycle
    logic obs_a;
    logic obs_b;

    regfile_wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.a_valid = v;
        bus.a_rd    = rd;
        bus.a_data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.b_valid = v;
        bus.b_rd    = rd;
        bus.b_data  = d;
    endtask

    // One clock: check readies mid-cycle, push the expected writeback, then
    // pop and compare it just after the rising edge.
    task automatic cycle();
        logic        ea;
        logic        eb;
        logic [4:0]  srd;
        logic [31:0] sdata;
        wb_item_t    it;
        wb_item_t    got;
        @(negedge clk);
        if (rst) begin
            ea = 1'b0;
            eb = 1'b0;
        end else if (bus.a_valid && bus.b_valid) begin
            ea = (m_last == 1'b1);
            eb = (m_last == 1'b0);
        end else begin
            ea = bus.a_valid;
            eb = bus.b_valid;
        end
        check("a_ready", bus.a_ready, ea);
        check("b_ready", bus.b_ready, eb);
        obs_a = bus.a_ready;
        obs_b = bus.b_ready;
        srd   = ea ? bus.a_rd : bus.b_rd;
        sdata = ea ? bus.a_data : bus.b_data;
        if (rst) begin
            m_rd   = '0;
            m_data = '0;
            m_last = 1'b1;
            m_cnt  = '0;
            it     = '0;
        end else begin
            it.wen = (ea || eb) && (srd != 5'd0);
            if (ea || eb) begin
                m_rd   = srd;
                m_data = sdata;
            end
            it.rd   = m_rd;
            it.data = m_data;
            if (ea) m_last = 1'b0;
            else if (eb) m_last = 1'b1;
            if (bus.a_valid && bus.b_valid && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        q.push_back(it);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty: observed=0 expected=1");
        end else begin
            got = q.pop_front();
            check("wb_wen", bus.wb_wen, got.wen);
            check("wb_rd", bus.wb_rd, got.rd);
            check("wb_data", bus.wb_data, got.data);
        end
        check("last_grant", bus.last_grant, m_last);
        check("conflict_cnt", bus.conflict_cnt, m_cnt);
        if (bus.wb_wen === 1'b1) rf[bus.wb_rd] = bus.wb_data;
    endtask

    initial begin
        logic [4:0] exp_rd34[3];
        logic       exp_b34[3];
        logic       prev_b;
        total  = 0;
        bad    = 0;
        m_last = 1'b1;
        m_cnt  = '0;
        m_rd   = '0;
        m_data = '0;
        obs_a  = 1'b0;
        obs_b  = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        exp_rd34 = '{5'd3, 5'd4, 5'd3};
        exp_b34  = '{1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);

        // Reset state
        cycle();
        cycle();
        #1 rst = 1'b0;
        check("rst_wb_wen", bus.wb_wen, 0);
        check("rst_wb_rd", bus.wb_rd, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_last_grant", bus.last_grant, 1);
        check("rst_conflict_cnt", bus.conflict_cnt, 0);
        cycle();

        // Single A write
        drive_a(1'b1, 5'd5, 32'h1234);
        cycle();
        check("t33_a_ready", obs_a, 1);
        check("t33_wb_wen", bus.wb_wen, 1);
        check("t33_wb_rd", bus.wb_rd, 5);
        check("t33_wb_data", bus.wb_data, 32'h1234);
        drive_a(1'b0, 5'd0, 32'h0);
        cycle();
        check("t33_idle_wen", bus.wb_wen, 0);
        check("t33_hold_rd", bus.wb_rd, 5);

        // Three cycles of contention after reset: A, B, A
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive_a(1'b1, 5'd3, 32'hA);
        drive_b(1'b1, 5'd4, 32'hB);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t34_grant_b", obs_b, exp_b34[i]);
            check("t34_wb_rd", bus.wb_rd, exp_rd34[i]);
        end
        check("t34_conflict_cnt", bus.conflict_cnt, 3);
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        cycle();

        // B writing x0 is consumed without a write
        drive_b(1'b1, 5'd0, 32'hFFFF);
        cycle();
        check("t35_b_ready", obs_b, 1);
        check("t35_wb_wen", bus.wb_wen, 0);
        check("t35_last_grant", bus.last_grant, 1);
        drive_b(1'b0, 5'd0, 32'h0);
        cycle();

        // Same destination from both: B first (last_grant=0), then A wins
        drive_a(1'b1, 5'd1, 32'h55);
        cycle();
        check("t36_last_a", bus.last_grant, 0);
        drive_a(1'b1, 5'd7, 32'h1);
        drive_b(1'b1, 5'd7, 32'h2);
        cycle();
        check("t36_first_b", obs_b, 1);
        drive_b(1'b0, 5'd0, 32'h0);
        cycle();
        check("t36_then_a", obs_a, 1);
        drive_a(1'b0, 5'd0, 32'h0);
        cycle();
        check("t36_x7", rf[7], 32'h1);

        // Reset right after a grant discards the pending write
        drive_a(1'b1, 5'd9, 32'h99);
        cycle();
        check("t37_granted_wen", bus.wb_wen, 1);
        drive_a(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        cycle();
        check("t37_wen", bus.wb_wen, 0);
        check("t37_rd", bus.wb_rd, 0);
        check("t37_data", bus.wb_data, 0);
        check("t37_last", bus.last_grant, 1);
        check("t37_cnt", bus.conflict_cnt, 0);
        rst = 1'b0;
        cycle();

        // Long contention: counter saturates, grants keep alternating
        drive_a(1'b1, 5'd3, 32'hA);
        drive_b(1'b1, 5'd4, 32'hB);
        for (int i = 0; i < 70000; i++) cycle();
        check("t38_cnt_sat", bus.conflict_cnt, 16'hFFFF);
        prev_b = obs_b;
        cycle();
        check("t38_alternate1", obs_b, !prev_b);
        check("t38_cnt_hold", bus.conflict_cnt, 16'hFFFF);
        prev_b = obs_b;
        cycle();
        check("t38_alternate2", obs_b, !prev_b);
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
